// File: rtl/issue_queue_mw_pkg.sv
// issue_queue_mw_pkg: shared issue-queue element type and the nop constant.
//   issue_queue_element_t : one decoded instruction as held in the queue
//   IQ_NOP                : all-zero element, driven on invalid output slots
package issue_queue_mw_pkg;

    typedef struct packed {
        logic [7:0] opcode;
        logic [5:0] rob_idx;
        logic [5:0] rd;
        logic [5:0] rs1;
        logic [5:0] rs2;
    } issue_queue_element_t;

    localparam issue_queue_element_t IQ_NOP = '0;

endpackage

// File: rtl/iq_count_clamp.sv
// iq_count_clamp: clamps enqueue/dequeue requests against queue occupancy.
//   count_i     : resident entries
//   flush_i     : forces in_accept_o to zero
//   in_num_i    : entries offered        -> in_accept_o = min(in_num, IN_W, free)
//   out_num_i   : entries requested      -> deq_o = min(out_num, avail)
//   free_o      : DEPTH - count
//   avail_o     : min(count, OUT_W)
module iq_count_clamp #(
    parameter int DEPTH = 16,
    parameter int IN_W  = 4,
    parameter int OUT_W = 2,
    parameter int CW    = $clog2(DEPTH) + 1,
    parameter int IW    = $clog2(IN_W + 1),
    parameter int OW    = $clog2(OUT_W + 1)
) (
    input  logic [CW-1:0] count_i,
    input  logic          flush_i,
    input  logic [IW-1:0] in_num_i,
    input  logic [OW-1:0] out_num_i,
    output logic [IW-1:0] in_accept_o,
    output logic [OW-1:0] deq_o,
    output logic [OW-1:0] avail_o,
    output logic [CW-1:0] free_o
);

    logic [31:0] acc, av, dq;

    // Ports may encode values above IN_W/OUT_W, so clamp to the port width too.
    always_comb begin
        free_o      = CW'(DEPTH) - count_i;
        acc         = 32'(in_num_i) > 32'(IN_W) ? 32'(IN_W) : 32'(in_num_i);
        acc         = acc > 32'(free_o) ? 32'(free_o) : acc;
        in_accept_o = flush_i ? '0 : IW'(acc);
        av          = 32'(count_i) > 32'(OUT_W) ? 32'(OUT_W) : 32'(count_i);
        avail_o     = OW'(av);
        dq          = 32'(out_num_i) > av ? av : 32'(out_num_i);
        deq_o       = OW'(dq);
    end

endmodule

// File: rtl/issue_queue_mw.sv
// issue_queue_mw: multi-port circular issue queue, IN_W enqueues / OUT_W dequeues per cycle.
//   clk, rst     : clock, synchronous active-high reset (priority over everything)
//   flush_i      : drop all entries; same-cycle traffic is discarded
//   in_data_i    : incoming entries, slot 0 oldest
//   in_num_i     : entries offered;  in_accept_o : entries taken this cycle
//   out_data_o   : oldest resident entries, slot 0 oldest; nop when invalid
//   out_valid_o  : slot i valid iff i < count
//   out_num_i    : entries consumed (clamped to avail)
//   count_o, free_o, avail_o : occupancy, DEPTH-count, min(count, OUT_W)
module issue_queue_mw
    import issue_queue_mw_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IN_W  = 4,
    parameter int OUT_W = 2
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         flush_i,
    input  issue_queue_element_t [IN_W-1:0]              in_data_i,
    input  logic                 [$clog2(IN_W+1)-1:0]    in_num_i,
    output logic                 [$clog2(IN_W+1)-1:0]    in_accept_o,
    output issue_queue_element_t [OUT_W-1:0]             out_data_o,
    output logic                 [OUT_W-1:0]             out_valid_o,
    input  logic                 [$clog2(OUT_W+1)-1:0]   out_num_i,
    output logic                 [$clog2(DEPTH)+1-1:0]   count_o,
    output logic                 [$clog2(DEPTH)+1-1:0]   free_o,
    output logic                 [$clog2(OUT_W+1)-1:0]   avail_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(OUT_W + 1);

    issue_queue_element_t storage_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] deq;

    iq_count_clamp #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W)) u_clamp (
        .count_i     (count_q),
        .flush_i     (flush_i),
        .in_num_i    (in_num_i),
        .out_num_i   (out_num_i),
        .in_accept_o (in_accept_o),
        .deq_o       (deq),
        .avail_o     (avail_o),
        .free_o      (free_o)
    );

    assign count_o = count_q;

    // Pointer arithmetic is PW bits wide, so windows wrap past DEPTH-1 for free.
    always_comb begin
        for (int i = 0; i < OUT_W; i++) begin
            out_valid_o[i] = count_q > CW'(i);
            out_data_o[i]  = out_valid_o[i] ? storage_q[tail_q + PW'(i)] : IQ_NOP;
        end
        head_d  = flush_i ? '0 : head_q + PW'(in_accept_o);
        tail_d  = flush_i ? '0 : tail_q + PW'(deq);
        count_d = flush_i ? '0 : count_q + CW'(in_accept_o) - CW'(deq);
    end

    // Storage needs no reset: slots are only observed through out_valid_o.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_W; i++)
            if (i < int'(in_accept_o)) storage_q[head_q + PW'(i)] <= in_data_i[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= CW'(DEPTH)) else $error("issue_queue_mw: count above DEPTH");
            assert (head_q == tail_q + PW'(count_q)) else $error("issue_queue_mw: pointer/count mismatch");
        end
    end

endmodule
